// File: rtl/keypad_scanner_if.sv
// Keypad-side and consumer-side signals of the keypad scanner.
// The slave modport is the scanner itself; the master modport is the keypad/consumer side.
interface keypad_scanner_if;
    logic [3:0] Cols;
    logic [3:0] Rows;
    logic [3:0] KeyCode;
    logic       KeyValid;
    logic       KeyAck;
    logic       KeyDown;
    logic       Overrun;

    modport master (
        output Cols,
        output KeyAck,
        input  Rows,
        input  KeyCode,
        input  KeyValid,
        input  KeyDown,
        input  Overrun
    );

    modport slave (
        input  Cols,
        input  KeyAck,
        output Rows,
        output KeyCode,
        output KeyValid,
        output KeyDown,
        output Overrun
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low row drive, builds a per-frame key map,
// debounces single-key presses and releases, and hands accepted keys to a consumer.
module keypad_scanner #(
    parameter int SCAN_BITS = 17,
    parameter int DB_FRAMES = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    keypad_scanner_if.slave  kp
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] DB_LAST = 4'(DB_FRAMES);

    logic [3:0]           cols_meta_reg;
    logic [3:0]           cols_sync_reg;
    logic [SCAN_BITS-1:0] scan_cnt_reg;
    logic [3:0]           rows_reg;
    logic [15:0]          map_reg;
    logic [15:0]          map_next;
    logic [15:0]          frame_map_reg;
    logic                 frame_done_reg;
    logic                 scan_end;
    logic                 frame_end;

    logic [4:0]           bit_count;
    logic [3:0]           frame_key;
    logic                 is_none;
    logic                 is_single;
    logic                 accept;

    state_t               state_reg;
    logic [3:0]           count_reg;
    logic [3:0]           cand_reg;
    logic [3:0]           key_code_reg;
    logic                 key_valid_reg;
    logic                 key_down_reg;
    logic                 overrun_reg;

    assign scan_end  = &scan_cnt_reg;
    assign frame_end = scan_end && (rows_reg == 4'h7);

    // Each row's nibble is refreshed only while that row is the one being driven low.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_map_row
            assign map_next[4*gi+3:4*gi] = (scan_end && !rows_reg[gi])
                                         ? ~cols_sync_reg
                                         : map_reg[4*gi+3:4*gi];
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cols_meta_reg  <= 4'hF;
            cols_sync_reg  <= 4'hF;
            scan_cnt_reg   <= '0;
            rows_reg       <= 4'hE;
            map_reg        <= '0;
            frame_map_reg  <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            cols_meta_reg  <= kp.Cols;
            cols_sync_reg  <= cols_meta_reg;
            scan_cnt_reg   <= scan_cnt_reg + SCAN_BITS'(1);
            map_reg        <= map_next;
            frame_done_reg <= frame_end;
            if (scan_end) begin
                rows_reg <= {rows_reg[2:0], rows_reg[3]};
            end
            if (frame_end) begin
                frame_map_reg <= map_next;
            end
        end
    end

    always_comb begin
        bit_count = '0;
        frame_key = '0;
        for (int i = 0; i < 16; i++) begin
            if (frame_map_reg[i]) begin
                bit_count = bit_count + 5'd1;
                frame_key = i[3:0];
            end
        end
    end

    assign is_none   = (bit_count == 5'd0);
    assign is_single = (bit_count == 5'd1);

    always_comb begin
        accept = 1'b0;
        if (frame_done_reg && is_single) begin
            if (state_reg == IDLE && DB_FRAMES == 1) begin
                accept = 1'b1;
            end else if (state_reg == DEBOUNCE && frame_key == cand_reg
                         && (count_reg + 4'd1) == DB_LAST) begin
                accept = 1'b1;
            end
        end
    end

    // Debounce FSM plus the consumer handshake; all outputs are registered here.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            cand_reg      <= '0;
            key_code_reg  <= 4'h0;
            key_valid_reg <= 1'b0;
            key_down_reg  <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            if (frame_done_reg) begin
                case (state_reg)
                    IDLE: begin
                        if (is_single) begin
                            cand_reg <= frame_key;
                            if (DB_FRAMES == 1) begin
                                state_reg    <= PRESSED;
                                key_down_reg <= 1'b1;
                                count_reg    <= '0;
                            end else begin
                                state_reg <= DEBOUNCE;
                                count_reg <= 4'd1;
                            end
                        end
                    end
                    DEBOUNCE: begin
                        if (is_single && frame_key == cand_reg) begin
                            if ((count_reg + 4'd1) == DB_LAST) begin
                                state_reg    <= PRESSED;
                                key_down_reg <= 1'b1;
                                count_reg    <= '0;
                            end else begin
                                count_reg <= count_reg + 4'd1;
                            end
                        end else if (is_single) begin
                            cand_reg  <= frame_key;
                            count_reg <= 4'd1;
                        end else begin
                            state_reg <= IDLE;
                            count_reg <= '0;
                        end
                    end
                    PRESSED: begin
                        if (is_none) begin
                            if (DB_FRAMES == 1) begin
                                state_reg    <= IDLE;
                                key_down_reg <= 1'b0;
                                count_reg    <= '0;
                            end else begin
                                state_reg <= RELEASE;
                                count_reg <= 4'd1;
                            end
                        end
                    end
                    RELEASE: begin
                        if (is_none) begin
                            if ((count_reg + 4'd1) == DB_LAST) begin
                                state_reg    <= IDLE;
                                key_down_reg <= 1'b0;
                                count_reg    <= '0;
                            end else begin
                                count_reg <= count_reg + 4'd1;
                            end
                        end else begin
                            state_reg <= PRESSED;
                            count_reg <= '0;
                        end
                    end
                    default: begin
                        state_reg    <= IDLE;
                        key_down_reg <= 1'b0;
                        count_reg    <= '0;
                    end
                endcase
            end

            // An acknowledge coinciding with a new key lets the new key replace the old one.
            if (accept) begin
                if (!key_valid_reg || kp.KeyAck) begin
                    key_code_reg  <= frame_key;
                    key_valid_reg <= 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end else if (key_valid_reg && kp.KeyAck) begin
                key_valid_reg <= 1'b0;
            end
        end
    end

    assign kp.Rows     = rows_reg;
    assign kp.KeyCode  = key_code_reg;
    assign kp.KeyValid = key_valid_reg;
    assign kp.KeyDown  = key_down_reg;
    assign kp.Overrun  = overrun_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with 64-cycle frames and 3-frame debounce;
// a small keypad model pulls columns low for held keys on the driven row.
module tb_keypad_scanner;

    logic        Clk;
    logic        Reset;
    logic [15:0] held;
    logic [3:0]  cols_model;
    int          vectors;
    int          miscompares;

    keypad_scanner_if kp();

    keypad_scanner #(
        .SCAN_BITS(4),
        .DB_FRAMES(3)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .kp    (kp)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always_comb begin
        cols_model = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (held[4*r+c] && !kp.Rows[r]) begin
                    cols_model[c] = 1'b0;
                end
            end
        end
    end

    assign kp.Cols = cols_model;

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset();
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        held        = 16'h0000;
        kp.KeyAck   = 1'b0;
        Reset       = 1'b0;

        // Reset values and row rotation timing
        pulse_reset();
        check("rst_rows",    16'(kp.Rows),     16'hE);
        check("rst_code",    16'(kp.KeyCode),  16'h0);
        check("rst_valid",   16'(kp.KeyValid), 16'h0);
        check("rst_down",    16'(kp.KeyDown),  16'h0);
        check("rst_overrun", 16'(kp.Overrun),  16'h0);
        release_reset();
        step(15);
        check("rows_15", 16'(kp.Rows), 16'hE);
        step(1);
        check("rows_16", 16'(kp.Rows), 16'hD);
        step(48);
        check("rows_64", 16'(kp.Rows), 16'hE);

        // Key 9 held: accepted after the third frame, reported once, then acked
        held = 16'h0200;
        pulse_reset();
        release_reset();
        step(192);
        check("k9_valid_pre", 16'(kp.KeyValid), 16'h0);
        check("k9_down_pre",  16'(kp.KeyDown),  16'h0);
        step(1);
        check("k9_valid", 16'(kp.KeyValid), 16'h1);
        check("k9_code",  16'(kp.KeyCode),  16'h9);
        check("k9_down",  16'(kp.KeyDown),  16'h1);
        step(130);
        check("k9_hold_valid",   16'(kp.KeyValid), 16'h1);
        check("k9_hold_overrun", 16'(kp.Overrun),  16'h0);
        kp.KeyAck = 1'b1;
        step(1);
        kp.KeyAck = 1'b0;
        check("k9_ack_clear", 16'(kp.KeyValid), 16'h0);
        step(64);
        check("k9_no_repeat", 16'(kp.KeyValid), 16'h0);
        check("k9_still_down", 16'(kp.KeyDown), 16'h1);

        // Key 9 bouncing one frame on, one frame off: never accepted
        held = 16'h0000;
        pulse_reset();
        release_reset();
        for (int p = 0; p < 3; p++) begin
            held = 16'h0200;
            step(64);
            held = 16'h0000;
            step(64);
            check("bounce_valid", 16'(kp.KeyValid), 16'h0);
            check("bounce_down",  16'(kp.KeyDown),  16'h0);
        end

        // Keys 0 and 5 together from idle: no report
        held = 16'h0021;
        pulse_reset();
        release_reset();
        step(320);
        check("multi_idle_valid", 16'(kp.KeyValid), 16'h0);
        check("multi_idle_down",  16'(kp.KeyDown),  16'h0);

        // Key 5 held and accepted, then key 0 added for 5 frames: stays pressed
        held = 16'h0020;
        pulse_reset();
        release_reset();
        step(193);
        check("k5_valid", 16'(kp.KeyValid), 16'h1);
        check("k5_code",  16'(kp.KeyCode),  16'h5);
        kp.KeyAck = 1'b1;
        step(1);
        kp.KeyAck = 1'b0;
        check("k5_ack_clear", 16'(kp.KeyValid), 16'h0);
        held = 16'h0021;
        step(320);
        check("multi_held_down",  16'(kp.KeyDown),  16'h1);
        check("multi_held_valid", 16'(kp.KeyValid), 16'h0);
        held = 16'h0020;
        step(128);
        check("k5_after_multi_down",  16'(kp.KeyDown),  16'h1);
        check("k5_after_multi_valid", 16'(kp.KeyValid), 16'h0);
        check("k5_after_multi_ovr",   16'(kp.Overrun),  16'h0);

        // Overrun: key 5 unacked, released 3 frames, then key A accepted
        held = 16'h0020;
        pulse_reset();
        release_reset();
        step(193);
        check("ovr_k5_valid", 16'(kp.KeyValid), 16'h1);
        held = 16'h0000;
        step(192);
        check("ovr_release_down", 16'(kp.KeyDown),  16'h0);
        check("ovr_release_valid", 16'(kp.KeyValid), 16'h1);
        held = 16'h0400;
        step(191);
        check("ovr_pre_overrun", 16'(kp.Overrun), 16'h0);
        step(1);
        check("ovr_code",    16'(kp.KeyCode),  16'h5);
        check("ovr_valid",   16'(kp.KeyValid), 16'h1);
        check("ovr_overrun", 16'(kp.Overrun),  16'h1);
        check("ovr_down",    16'(kp.KeyDown),  16'h1);
        held = 16'h0000;
        step(192);
        check("ackacc_release_down", 16'(kp.KeyDown), 16'h0);
        held = 16'h0400;
        step(191);
        kp.KeyAck = 1'b1;
        step(1);
        kp.KeyAck = 1'b0;
        check("ackacc_code",    16'(kp.KeyCode),  16'hA);
        check("ackacc_valid",   16'(kp.KeyValid), 16'h1);
        check("ackacc_overrun", 16'(kp.Overrun),  16'h1);
        step(1);
        check("ackacc_valid_hold", 16'(kp.KeyValid), 16'h1);

        // Reset in the middle of debounce discards progress
        held = 16'h0200;
        pulse_reset();
        release_reset();
        step(129);
        pulse_reset();
        check("midrst_rows",  16'(kp.Rows),     16'hE);
        check("midrst_valid", 16'(kp.KeyValid), 16'h0);
        check("midrst_down",  16'(kp.KeyDown),  16'h0);
        check("midrst_code",  16'(kp.KeyCode),  16'h0);
        release_reset();
        step(192);
        check("midrst_valid_pre", 16'(kp.KeyValid), 16'h0);
        step(1);
        check("midrst_valid_post", 16'(kp.KeyValid), 16'h1);
        check("midrst_code_post",  16'(kp.KeyCode),  16'h9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
